// File: rtl/ysyx_axi4_sram_if.sv
// AXI4 read/write channel bundle for ysyx_axi4_sram (ID 4, address 32, data 64).
interface ysyx_axi4_sram_if;
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic        arvalid;
  logic        arready;
  logic [3:0]  rid;
  logic [63:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic        rvalid;
  logic        rready;
  logic [3:0]  awid;
  logic [31:0] awaddr;
  logic [7:0]  awlen;
  logic        awvalid;
  logic        awready;
  logic [63:0] wdata;
  logic [7:0]  wstrb;
  logic        wlast;
  logic        wvalid;
  logic        wready;
  logic [3:0]  bid;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;

  modport slave (
    input  arid, araddr, arlen, arvalid, rready,
    input  awid, awaddr, awlen, awvalid, wdata, wstrb, wlast, wvalid, bready,
    output arready, rid, rdata, rresp, rlast, rvalid,
    output awready, wready, bid, bresp, bvalid
  );

  modport master (
    output arid, araddr, arlen, arvalid, rready,
    output awid, awaddr, awlen, awvalid, wdata, wstrb, wlast, wvalid, bready,
    input  arready, rid, rdata, rresp, rlast, rvalid,
    input  awready, wready, bid, bresp, bvalid
  );
endinterface

// File: rtl/ysyx_axi4_sram.sv
// AXI4 INCR-burst SRAM slave with independent read and write engines.
// Define YSYX_SRAM_DELAY_EN to insert LFSR-driven wait states on every channel.
module ysyx_axi4_sram #(
  parameter logic [31:0] BASE  = 32'h8000_0000,
  parameter int unsigned DEPTH = 4096
) (
  input logic             clk,
  input logic             rst,
  ysyx_axi4_sram_if.slave bus
);
  localparam int unsigned AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [32:0] LIMIT = {1'b0, BASE} + 33'(DEPTH) * 33'd8;

  typedef enum logic       {RIdle, RData}        r_state_e;
  typedef enum logic [1:0] {WIdle, WData, WResp} w_state_e;

  logic [63:0] r_mem [DEPTH];

  function automatic logic in_range(input logic [31:0] a);
    return ({1'b0, a} >= {1'b0, BASE}) && ({1'b0, a} < LIMIT);
  endfunction

  function automatic logic [AW-1:0] word_idx(input logic [31:0] a);
    return AW'((a - BASE) >> 3);
  endfunction

  logic w_gate;
`ifdef YSYX_SRAM_DELAY_EN
  logic [19:0] r_lfsr;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_lfsr <= 20'd1;
    else      r_lfsr <= {r_lfsr[18:0], r_lfsr[19] ^ r_lfsr[18]};
  end
  assign w_gate = r_lfsr[19];
`else
  assign w_gate = 1'b1;
`endif

  // Read engine
  r_state_e    r_rstate, w_rstate_d;
  logic        r_arready, r_rvalid, r_rlast;
  logic [3:0]  r_rid;
  logic [31:0] r_raddr, w_raddr_n;
  logic [7:0]  r_rlen, r_rcnt, w_rlen_n, w_rcnt_n;
  logic [63:0] r_rdata;
  logic [1:0]  r_rresp;
  logic        w_ar_hs, w_r_hs, w_rload;

  assign w_ar_hs   = bus.arvalid & r_arready;
  assign w_r_hs    = r_rvalid & bus.rready;
  // A beat is fetched at capture, after a non-final accept, or late when the gate was closed.
  assign w_rload   = w_gate & (w_ar_hs | ((r_rstate == RData) & ~r_rvalid) | (w_r_hs & ~r_rlast));
  assign w_raddr_n = w_ar_hs ? bus.araddr : (w_r_hs ? r_raddr + 32'd8 : r_raddr);
  assign w_rcnt_n  = w_ar_hs ? 8'd0 : (w_r_hs ? r_rcnt + 8'd1 : r_rcnt);
  assign w_rlen_n  = w_ar_hs ? bus.arlen : r_rlen;

  always_comb begin
    w_rstate_d = r_rstate;
    case (r_rstate)
      RIdle:   if (w_ar_hs) w_rstate_d = RData;
      RData:   if (w_r_hs && r_rlast) w_rstate_d = RIdle;
      default: w_rstate_d = RIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_rstate <= RIdle;
    else      r_rstate <= w_rstate_d;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_arready <= 1'b0;
      r_rvalid  <= 1'b0;
      r_rlast   <= 1'b0;
      r_rid     <= 4'd0;
      r_raddr   <= 32'd0;
      r_rlen    <= 8'd0;
      r_rcnt    <= 8'd0;
      r_rdata   <= 64'd0;
      r_rresp   <= 2'b00;
    end else begin
      r_arready <= (w_rstate_d == RIdle) & w_gate;
      if (w_ar_hs) r_rid <= bus.arid;
      r_raddr <= w_raddr_n;
      r_rcnt  <= w_rcnt_n;
      r_rlen  <= w_rlen_n;
      if (w_rload) begin
        r_rvalid <= 1'b1;
        r_rlast  <= (w_rcnt_n == w_rlen_n);
        if (in_range(w_raddr_n)) begin
          r_rdata <= r_mem[word_idx(w_raddr_n)];
          r_rresp <= 2'b00;
        end else begin
          r_rdata <= 64'd0;
          r_rresp <= 2'b10;
        end
      end else if (w_r_hs) begin
        r_rvalid <= 1'b0;
        r_rlast  <= 1'b0;
      end
    end
  end

  // Write engine
  w_state_e    r_wstate, w_wstate_d;
  logic        r_awready, r_wready, r_bvalid, r_werr;
  logic [3:0]  r_wid;
  logic [31:0] r_waddr;
  logic [7:0]  r_wlen, r_wcnt;
  logic [1:0]  r_bresp;
  logic        w_aw_hs, w_w_hs, w_b_hs, w_wok;

  assign w_aw_hs = bus.awvalid & r_awready;
  assign w_w_hs  = bus.wvalid & r_wready;
  assign w_b_hs  = r_bvalid & bus.bready;
  assign w_wok   = in_range(r_waddr);

  always_comb begin
    w_wstate_d = r_wstate;
    case (r_wstate)
      WIdle:   if (w_aw_hs) w_wstate_d = WData;
      WData:   if (w_w_hs && bus.wlast) w_wstate_d = WResp;
      WResp:   if (w_b_hs) w_wstate_d = WIdle;
      default: w_wstate_d = WIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_wstate <= WIdle;
    else      r_wstate <= w_wstate_d;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_awready <= 1'b0;
      r_wready  <= 1'b0;
      r_bvalid  <= 1'b0;
      r_werr    <= 1'b0;
      r_wid     <= 4'd0;
      r_waddr   <= 32'd0;
      r_wlen    <= 8'd0;
      r_wcnt    <= 8'd0;
      r_bresp   <= 2'b00;
    end else begin
      r_awready <= (w_wstate_d == WIdle) & w_gate;
      r_wready  <= (w_wstate_d == WData) & w_gate;
      if (w_aw_hs) begin
        r_wid   <= bus.awid;
        r_waddr <= bus.awaddr;
        r_wlen  <= bus.awlen;
        r_wcnt  <= 8'd0;
        r_werr  <= 1'b0;
      end
      if (w_w_hs) begin
        r_waddr <= r_waddr + 32'd8;
        r_wcnt  <= r_wcnt + 8'd1;
        r_werr  <= r_werr | ~w_wok;
        if (bus.wlast) begin
          r_bvalid <= 1'b1;
          r_bresp  <= (r_werr || !w_wok || (r_wcnt != r_wlen)) ? 2'b10 : 2'b00;
        end
      end
      if (w_b_hs) r_bvalid <= 1'b0;
    end
  end

  // Array has no reset so contents survive a reset pulse.
  always_ff @(posedge clk) begin
    if (w_w_hs && w_wok) begin
      for (int i = 0; i < 8; i++) begin
        if (bus.wstrb[i]) r_mem[word_idx(r_waddr)][8*i +: 8] <= bus.wdata[8*i +: 8];
      end
    end
  end

  assign bus.arready = r_arready;
  assign bus.rid     = r_rid;
  assign bus.rdata   = r_rdata;
  assign bus.rresp   = r_rresp;
  assign bus.rlast   = r_rlast;
  assign bus.rvalid  = r_rvalid;
  assign bus.awready = r_awready;
  assign bus.wready  = r_wready;
  assign bus.bid     = r_wid;
  assign bus.bresp   = r_bresp;
  assign bus.bvalid  = r_bvalid;
endmodule

// File: tb/tb_ysyx_axi4_sram.sv
// Directed bench for ysyx_axi4_sram: bursts, strobes, range edge, back-pressure, reset.
module tb_ysyx_axi4_sram;
  localparam logic [31:0] BASE = 32'h8000_0000;
  localparam int          TMO  = 100;

  logic clk, rst;
  ysyx_axi4_sram_if bus ();

  ysyx_axi4_sram #(.BASE(BASE), .DEPTH(4096)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  logic [63:0] wbuf [8];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic ar_send(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len);
    int n = 0;
    bus.arid = id; bus.araddr = addr; bus.arlen = len; bus.arvalid = 1'b1;
    while (!bus.arready && n < TMO) begin @(negedge clk); n++; end
    if (n >= TMO) check("ar_timeout", 1, 0);
    @(negedge clk);
    bus.arvalid = 1'b0;
  endtask

  task automatic r_get(output logic [63:0] d, output logic [1:0] rs, output logic l,
                       output logic [3:0] id);
    int n = 0;
    bus.rready = 1'b1;
    while (!bus.rvalid && n < TMO) begin @(negedge clk); n++; end
    if (n >= TMO) check("r_timeout", 1, 0);
    d = bus.rdata; rs = bus.rresp; l = bus.rlast; id = bus.rid;
    @(negedge clk);
  endtask

  task automatic write_burst(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                             input int nbeats, input logic [7:0] strb,
                             output logic [1:0] resp, output logic [3:0] bid);
    int n = 0;
    bus.awid = id; bus.awaddr = addr; bus.awlen = len; bus.awvalid = 1'b1;
    while (!bus.awready && n < TMO) begin @(negedge clk); n++; end
    if (n >= TMO) check("aw_timeout", 1, 0);
    @(negedge clk);
    bus.awvalid = 1'b0;
    for (int i = 0; i < nbeats; i++) begin
      bus.wdata = wbuf[i]; bus.wstrb = strb; bus.wlast = (i == nbeats - 1); bus.wvalid = 1'b1;
      n = 0;
      while (!bus.wready && n < TMO) begin @(negedge clk); n++; end
      if (n >= TMO) check("w_timeout", 1, 0);
      @(negedge clk);
    end
    bus.wvalid = 1'b0; bus.wlast = 1'b0;
    bus.bready = 1'b1;
    n = 0;
    while (!bus.bvalid && n < TMO) begin @(negedge clk); n++; end
    if (n >= TMO) check("b_timeout", 1, 0);
    resp = bus.bresp; bid = bus.bid;
    @(negedge clk);
    bus.bready = 1'b0;
  endtask

  logic [63:0] d;
  logic [1:0]  rs;
  logic        l;
  logic [3:0]  id;

  initial begin
    rst = 1'b0;
    bus.arid = '0; bus.araddr = '0; bus.arlen = '0; bus.arvalid = 1'b0; bus.rready = 1'b0;
    bus.awid = '0; bus.awaddr = '0; bus.awlen = '0; bus.awvalid = 1'b0;
    bus.wdata = '0; bus.wstrb = '0; bus.wlast = 1'b0; bus.wvalid = 1'b0; bus.bready = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_arready", bus.arready, 0);
    check("rst_awready", bus.awready, 0);
    check("rst_wready", bus.wready, 0);
    check("rst_rvalid", bus.rvalid, 0);
    check("rst_bvalid", bus.bvalid, 0);
    check("rst_rdata", bus.rdata, 0);
    rst = 1'b1;
    @(negedge clk);
    check("post_rst_arready", bus.arready, 1);
    check("post_rst_awready", bus.awready, 1);

    // Four-beat write then read back
    wbuf[0] = 64'd1; wbuf[1] = 64'd2; wbuf[2] = 64'd3; wbuf[3] = 64'd4;
    write_burst(4'h5, BASE, 8'd3, 4, 8'hFF, rs, id);
    check("wr4_bresp", rs, 2'b00);
    check("wr4_bid", id, 4'h5);
    ar_send(4'h9, BASE, 8'd3);
    for (int i = 0; i < 4; i++) begin
      r_get(d, rs, l, id);
      check($sformatf("rd4_data%0d", i), d, 64'(i + 1));
      check($sformatf("rd4_resp%0d", i), rs, 2'b00);
      check($sformatf("rd4_last%0d", i), l, (i == 3));
    end
    check("rd4_rid", id, 4'h9);
    bus.rready = 1'b0;

    // Partial strobe with unaligned awaddr over zero
    wbuf[0] = 64'd0;
    write_burst(4'h1, BASE + 32'h20, 8'd0, 1, 8'hFF, rs, id);
    wbuf[0] = 64'hAAAA_BBBB_CCCC_DDDD;
    write_burst(4'h1, BASE + 32'h23, 8'd0, 1, 8'h0F, rs, id);
    check("strb_bresp", rs, 2'b00);
    ar_send(4'h2, BASE + 32'h20, 8'd0);
    r_get(d, rs, l, id);
    check("strb_data", d, 64'h0000_0000_CCCC_DDDD);
    check("strb_last", l, 1);
    bus.rready = 1'b0;

    // Read running off the top of the array
    wbuf[0] = 64'h1234_5678_9ABC_DEF0;
    write_burst(4'h3, BASE + 32'h7FF8, 8'd0, 1, 8'hFF, rs, id);
    check("top_wr_bresp", rs, 2'b00);
    ar_send(4'h4, BASE + 32'h7FF8, 8'd1);
    r_get(d, rs, l, id);
    check("edge_b1_data", d, 64'h1234_5678_9ABC_DEF0);
    check("edge_b1_resp", rs, 2'b00);
    check("edge_b1_last", l, 0);
    r_get(d, rs, l, id);
    check("edge_b2_data", d, 64'd0);
    check("edge_b2_resp", rs, 2'b10);
    check("edge_b2_last", l, 1);
    bus.rready = 1'b0;

    // Write below BASE is suppressed with SLVERR
    wbuf[0] = 64'hDEAD;
    write_burst(4'h6, 32'h7FFF_FFF8, 8'd0, 1, 8'hFF, rs, id);
    check("oor_wr_bresp", rs, 2'b10);

    // Back-pressure mid-burst
    ar_send(4'h7, BASE, 8'd3);
    r_get(d, rs, l, id);
    check("bp_b1_data", d, 64'd1);
    bus.rready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check($sformatf("bp_hold_valid%0d", i), bus.rvalid, 1);
      check($sformatf("bp_hold_data%0d", i), bus.rdata, 64'd2);
      check($sformatf("bp_hold_last%0d", i), bus.rlast, 0);
      @(negedge clk);
    end
    for (int i = 1; i < 4; i++) begin
      r_get(d, rs, l, id);
      check($sformatf("bp_data%0d", i), d, 64'(i + 1));
      check($sformatf("bp_last%0d", i), l, (i == 3));
    end
    bus.rready = 1'b0;

    // Early wlast: awlen 3 but only two beats
    wbuf[0] = 64'h11; wbuf[1] = 64'h22;
    write_burst(4'h8, BASE + 32'h40, 8'd3, 2, 8'hFF, rs, id);
    check("short_bresp", rs, 2'b10);

    // Reset pulse during beat 2 of an 8-beat read
    ar_send(4'hA, BASE, 8'd7);
    r_get(d, rs, l, id);
    check("rst_b1_data", d, 64'd1);
    bus.rready = 1'b0;
    check("rst_b2_valid", bus.rvalid, 1);
    #2 rst = 1'b0;
    #1;
    check("async_rvalid", bus.rvalid, 0);
    check("async_arready", bus.arready, 0);
    check("async_rdata", bus.rdata, 0);
    check("async_rid", bus.rid, 0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("rel_arready", bus.arready, 1);
    ar_send(4'hB, BASE + 32'h8, 8'd0);
    r_get(d, rs, l, id);
    check("retain_data", d, 64'd2);
    check("retain_last", l, 1);
    bus.rready = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/ysyx_axi4_sram.md
YSYX_AXI4_SRAM -- requirements
Module: ysyx_axi4_sram

Interface
REQ-001 SHALL have parameter BASE, default 32'h8000_0000, byte address of word 0.
REQ-002 SHALL have parameter DEPTH, default 4096, number of 64-bit words in the array.
REQ-003 SHALL have port clk  in  1  single clock, all state on rising edge.
REQ-004 SHALL have port rst  in  1  asynchronous active-low reset.
REQ-005 SHALL have port arid  in  4  read ID.
REQ-006 SHALL have port araddr  in  32  read start byte address.
REQ-007 SHALL have port arlen  in  8  read beats minus one, INCR burst.
REQ-008 SHALL have port arvalid  in  1  read address valid.
REQ-009 SHALL have port arready  out  1  read address ready.
REQ-010 SHALL have port rid  out  4  echo of captured arid.
REQ-011 SHALL have port rdata  out  64  read beat data.
REQ-012 SHALL have port rresp  out  2  2'b00 OKAY, 2'b10 SLVERR.
REQ-013 SHALL have port rlast  out  1  final read beat.
REQ-014 SHALL have port rvalid  out  1  read beat valid.
REQ-015 SHALL have port rready  in  1  read beat accept.
REQ-016 SHALL have port awid  in  4  write ID.
REQ-017 SHALL have port awaddr  in  32  write start byte address.
REQ-018 SHALL have port awlen  in  8  write beats minus one, INCR burst.
REQ-019 SHALL have port awvalid  in  1  write address valid.
REQ-020 SHALL have port awready  out  1  write address ready.
REQ-021 SHALL have port wdata  in  64  write beat data.
REQ-022 SHALL have port wstrb  in  8  byte enables, bit i = wdata[8i+7:8i].
REQ-023 SHALL have port wlast  in  1  final write beat.
REQ-024 SHALL have port wvalid  in  1  write beat valid.
REQ-025 SHALL have port wready  out  1  write beat ready.
REQ-026 SHALL have port bid  out  4  echo of captured awid.
REQ-027 SHALL have port bresp  out  2  write response.
REQ-028 SHALL have port bvalid  out  1  write response valid.
REQ-029 SHALL have port bready  in  1  write response accept.

Function
REQ-030 SHALL run independent read FSM (R_IDLE, R_DATA) and write FSM (W_IDLE, W_DATA, W_RESP) concurrently.
REQ-031 SHALL drive arready=1 only in R_IDLE; arvalid&arready captures arid/araddr/arlen, beat count 0, next state R_DATA.
REQ-032 SHALL in R_DATA assert rvalid from the cycle after capture; rdata registered from array at beat start; rlast=1 when beat count==captured len.
REQ-033 SHALL hold rvalid/rdata/rresp/rlast/rid stable while rready=0; each rvalid&rready advances address by 8 and count by 1; handshake with rlast returns to R_IDLE (arready re-asserts next cycle, no same-cycle restart).
REQ-034 SHALL drive awready=1 only in W_IDLE; capture awid/awaddr/awlen, go to W_DATA; wready=1 only in W_DATA.
REQ-035 SHALL on each wvalid&wready write only strobed bytes to current word, address +8, count +1; wlast handshake moves to W_RESP.
REQ-036 SHALL report bresp=2'b10 if wlast arrives with count!=awlen or any beat was out of range, else 2'b00; bvalid held until bready, then W_IDLE.
REQ-037 SHALL treat a beat as out of range when address<BASE or address>=BASE+8*DEPTH, checked per beat (bursts may run off the end): reads return rdata=0 rresp=2'b10, writes suppressed.
REQ-038 SHALL, when a write and a read beat start on the same word in the same cycle, return pre-write data; an already-presented rdata SHALL NOT change due to later writes.
REQ-039 SHALL ignore araddr[2:0]/awaddr[2:0] for word select; sub-word writes rely solely on wstrb.

Reset
REQ-040 SHALL on rst=0 immediately force R_IDLE, W_IDLE, arready=0, awready=0, wready=0, rvalid=0, bvalid=0, rlast=0, rdata=0, rresp=0, bresp=0, rid=0, bid=0, mid-burst included; array contents retained.
REQ-041 SHALL assert arready/awready starting the first clk edge after rst deasserts.

Configuration
REQ-042 SHALL, with YSYX_SRAM_DELAY_EN defined, run a 20-bit LFSR (seed 1, shift-in lfsr[19]^lfsr[18] every cycle) and gate arready, awready, wready, and new rvalid assertion with lfsr[19]; once raised, rvalid SHALL stay high until handshake.
REQ-043 SHALL, without YSYX_SRAM_DELAY_EN, contain no LFSR and add no wait states.

Verification
REQ-044 SHALL test write araddr 8000_0000 len 3 data 1,2,3,4 wstrb FF, then read same -> rdata 1,2,3,4, rlast on beat 4, bresp/rresp 00.
REQ-045 SHALL test wstrb 8'h0F data 64'hAAAA_BBBB_CCCC_DDDD over 64'h0 -> reads 64'h0000_0000_CCCC_DDDD.
REQ-046 SHALL test read BASE+8*DEPTH-8 len 1 -> beat 1 rresp 00, beat 2 rresp 10 rdata 0.
REQ-047 SHALL test rready low 5 cycles mid-burst -> rdata/rlast stable; awlen 3 with wlast on beat 2 -> bresp 10.
REQ-048 SHALL test rst pulse during beat 2 of an 8-beat read -> rvalid 0 at once, arready 1 one edge after release.
